// File: rtl/nice_range_iterator.sv
// Range iterator: accepts (start, step, count) and streams start + k*step for k = 0..count-1.
// Optional NICE_RANGE_ITERATOR_ABORT_EN adds an abort input and an aborted status pulse.
module nice_range_iterator #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_start,
  input  logic [DATA_W-1:0] cmd_step,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_index,
  output logic              out_last,
  output logic              done,
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] step_r;
  logic [CNT_W-1:0]  count_r;
  logic              done_nxt;
  logic              load;
  logic              advance;
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
  logic              aborted_nxt;
`endif

  assign cmd_ready = (state == IDLE) && !rst;
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
    aborted_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          // A zero-length range completes immediately without leaving IDLE.
          if (cmd_count != '0) begin
            state_nxt = RUN;
            load      = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (out_last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
        if (abort) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      step_r    <= '0;
      count_r   <= '0;
      done      <= 1'b0;
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done <= done_nxt;
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
      aborted <= aborted_nxt;
`endif
      if (load) begin
        out_data  <= cmd_start;
        step_r    <= cmd_step;
        count_r   <= cmd_count;
        out_index <= '0;
        out_last  <= (cmd_count == CNT_W'(1));
      end else if (advance) begin
        out_data  <= out_data + step_r;
        out_index <= out_index + CNT_W'(1);
        // Look one beat ahead so out_last is registered with its beat.
        out_last  <= ((out_index + CNT_W'(1)) == (count_r - CNT_W'(1)));
      end
    end
  end

endmodule

// File: tb/tb_nice_range_iterator.sv
// Directed self-checking bench for nice_range_iterator (DATA_W=8 to exercise wrap-around).
module tb_nice_range_iterator;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_start;
  logic [7:0]  cmd_step;
  logic [15:0] cmd_count;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_index;
  logic        out_last;
  logic        done;
  logic        busy;
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int checks = 0;
  int errors = 0;

  nice_range_iterator #(
    .DATA_W(8),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_step (cmd_step),
    .cmd_count(cmd_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .done     (done),
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready_in_rst: got %b want 0", cmd_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, out_valid, out_last, done, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/val/last/done/busy=%b want 10000",
               {cmd_ready, out_valid, out_last, done, busy});
    end
    checks++;
    if (out_data !== 8'h00 || out_index !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%h idx=%0d want 00/0", out_data, out_index);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] e;
    out_ready = 1'b1;
    cmd_start = 8'h10; cmd_step = 8'd4; cmd_count = 16'd4; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = 8'h10 + 8'(4 * i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || out_index !== 16'(i)) begin
        errors++;
        $display("FAIL basic_beat%0d: got val=%b data=%h idx=%0d want 1/%h/%0d",
                 i, out_valid, out_data, out_index, e, i);
      end
      checks++;
      if (out_last !== (i == 3) || done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_flags%0d: got last/done/busy/rdy=%b%b%b%b want %b010",
                 i, out_last, done, busy, cmd_ready, (i == 3));
      end
      tick();
    end
    checks++;
    if ({out_valid, done, busy, cmd_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL basic_done: got val/done/busy/rdy=%b want 0101",
               {out_valid, done, busy, cmd_ready});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    cmd_start = 8'd5; cmd_step = 8'd1; cmd_count = 16'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd5 || out_index !== 16'd0) begin
      errors++;
      $display("FAIL bp_beat0: got val=%b data=%0d idx=%0d want 1/5/0", out_valid, out_data, out_index);
    end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd6 || out_index !== 16'd1 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got val=%b data=%0d idx=%0d last=%b want 1/6/1/0",
                 i, out_valid, out_data, out_index, out_last);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd6 || out_index !== 16'd1) begin
      errors++;
      $display("FAIL bp_release: got val=%b data=%0d idx=%0d want 1/6/1", out_valid, out_data, out_index);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd7 || out_index !== 16'd2 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_beat2: got val=%b data=%0d idx=%0d last=%b want 1/7/2/1",
               out_valid, out_data, out_index, out_last);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got val=%b done=%b want 0/1", out_valid, done);
    end
    tick();
  endtask

  task automatic test_wrap_negative();
    logic [7:0] exp_wrap [3];
    logic [7:0] exp_neg  [3];
    exp_wrap = '{8'hFE, 8'hFF, 8'h00};
    exp_neg  = '{8'h02, 8'h01, 8'h00};
    out_ready = 1'b1;
    cmd_start = 8'hFE; cmd_step = 8'h01; cmd_count = 16'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_wrap[i] || out_last !== (i == 2)) begin
        errors++;
        $display("FAIL wrap_beat%0d: got val=%b data=%h last=%b want 1/%h/%b",
                 i, out_valid, out_data, out_last, exp_wrap[i], (i == 2));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got val=%b done=%b want 0/1", out_valid, done);
    end
    cmd_start = 8'h02; cmd_step = 8'hFF; cmd_count = 16'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_neg[i] || out_index !== 16'(i)) begin
        errors++;
        $display("FAIL neg_beat%0d: got val=%b data=%h idx=%0d want 1/%h/%0d",
                 i, out_valid, out_data, out_index, exp_neg[i], i);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL neg_done: got val=%b done=%b want 0/1", out_valid, done);
    end
    tick();
  endtask

  task automatic test_zero_single();
    out_ready = 1'b1;
    cmd_start = 8'h33; cmd_step = 8'h01; cmd_count = 16'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({out_valid, done, cmd_ready, busy} !== 4'b0110) begin
      errors++;
      $display("FAIL zero_len: got val/done/rdy/busy=%b want 0110",
               {out_valid, done, cmd_ready, busy});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: got val=%b done=%b want 0/0", out_valid, done);
    end
    cmd_start = 8'd9; cmd_step = 8'd3; cmd_count = 16'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd9 || out_index !== 16'd0 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: got val=%b data=%0d idx=%0d last=%b want 1/9/0/1",
               out_valid, out_data, out_index, out_last);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got val=%b done=%b want 0/1", out_valid, done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    cmd_start = 8'h20; cmd_step = 8'd1; cmd_count = 16'd2; cmd_valid = 1'b1;
    tick();
    cmd_start = 8'h40; cmd_step = 8'd2; cmd_count = 16'd2;
    checks++;
    if (out_data !== 8'h20 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_a0: got data=%h rdy=%b want 20/0", out_data, cmd_ready);
    end
    tick();
    checks++;
    if (out_data !== 8'h21 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a1: got data=%h last=%b want 21/1", out_data, out_last);
    end
    tick();
    checks++;
    if ({out_valid, done, cmd_ready} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_bubble: got val/done/rdy=%b want 011", {out_valid, done, cmd_ready});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h40 || out_index !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_b0: got val=%b data=%h idx=%0d done=%b want 1/40/0/0",
               out_valid, out_data, out_index, done);
    end
    tick();
    checks++;
    if (out_data !== 8'h42 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_b1: got data=%h last=%b want 42/1", out_data, out_last);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got val=%b done=%b want 0/1", out_valid, done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    cmd_start = 8'h00; cmd_step = 8'd1; cmd_count = 16'd8; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 16'd2) begin
      errors++;
      $display("FAIL rstmid_beat2: got val=%b idx=%0d want 1/2", out_valid, out_index);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_in_rst: got val=%b rdy=%b done=%b want 0/0/0", out_valid, cmd_ready, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({out_valid, done, cmd_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_after: got val/done/rdy/busy=%b want 0010",
               {out_valid, done, cmd_ready, busy});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: got val=%b done=%b want 0/0", out_valid, done);
    end
  endtask

`ifdef NICE_RANGE_ITERATOR_ABORT_EN
  task automatic test_abort();
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got done=%b aborted=%b want 0/0", done, aborted);
    end
    abort = 1'b0;
    cmd_start = 8'h00; cmd_step = 8'd1; cmd_count = 16'd10; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd3 || out_index !== 16'd3) begin
      errors++;
      $display("FAIL abort_beat3: got val=%b data=%0d idx=%0d want 1/3/3", out_valid, out_data, out_index);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({out_valid, done, aborted, busy, cmd_ready} !== 5'b01101) begin
      errors++;
      $display("FAIL abort_end: got val/done/abt/busy/rdy=%b want 01101",
               {out_valid, done, aborted, busy, cmd_ready});
    end
    tick();
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: got done=%b aborted=%b val=%b want 0/0/0", done, aborted, out_valid);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_step = '0;
    cmd_count = '0;
    out_ready = 1'b0;
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_negative();
    test_zero_single();
    test_back_to_back();
    test_reset_mid();
`ifdef NICE_RANGE_ITERATOR_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
